spi_arb: RTL and testbench

Arbiter and sequencer that shares the single SPI master among several on-chip requesters (command processor gain/trigger writes, EEPROM calibration reader, spare). It grants one requester at a time with round-robin fairness, launches the SPI write, and holds a registered slave ID for the whole transaction. It decodes that ID into the five active-low slave selects: trigger, ch1/ch2/ch3 gain pots, and EEPROM. It captures the read-back word and returns a done or error pulse to the owning requester. It sits between the requesters and the SPI master, replacing ad-hoc combinational select decode.

---
 rtl/dso_spi_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/spi_arb.sv | 151 +++++++++++++++
 tb/tb_spi_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dso_spi_pkg
// Description : Shared SPI constants for the DSO SPI arbiter: slave IDs,
//               arbiter FSM state encoding, SPI word width.
// Revision    : 1.0 - initial release
// ============================================================================
package dso_spi_pkg;

    localparam int SPI_W = 16;

    // Slave IDs as carried on req_sel; 5..7 never address a device
    localparam logic [2:0] SLV_TRIG = 3'd0;
    localparam logic [2:0] SLV_CH1  = 3'd1;
    localparam logic [2:0] SLV_CH2  = 3'd2;
    localparam logic [2:0] SLV_CH3  = 3'd3;
    localparam logic [2:0] SLV_EEP  = 3'd4;
    localparam logic [2:0] SLV_NONE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_BUSY   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // True when the ID addresses a real slave device
    function automatic logic sel_legal(input logic [2:0] sel);
        return (sel <= SLV_EEP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches req starting one
//               past last_grant (wrapping) and returns the first set index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       valid
);

    localparam int IW = $clog2(NUM_REQ);

    // One extra bit so last_grant + offset never overflows before the wrap
    logic [IW:0] w_sum;

    // Walk offsets from farthest to nearest so the nearest asserted req wins
    always_comb begin
        grant = '0;
        valid = 1'b0;
        w_sum = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_sum = {1'b0, last_grant} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IW+1)'(NUM_REQ);
            end
            if (req[w_sum[IW-1:0]]) begin
                grant = w_sum[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : spi_arb
// Description : Shares one SPI master among NUM_REQ requesters. Round-robin
//               grant, one-cycle launch, timeout abort, registered slave ID
//               decoded into five active-low selects, read-back capture.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arb
    import dso_spi_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_sel,
    input  logic [16*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic [15:0]            rdata,
    output logic                   busy,
    output logic                   wrt_SPI,
    output logic [15:0]            SPI_data,
    input  logic                   SPI_done,
    input  logic [15:0]            data_in,
    input  logic                   SS_n,
    output logic                   trig_ss_n,
    output logic                   ch1_ss_n,
    output logic                   ch2_ss_n,
    output logic                   ch3_ss_n,
    output logic                   EEP_ss_n
);

    localparam int              IW         = $clog2(NUM_REQ);
    localparam int              CW         = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   C_GNT_RST  = IW'(NUM_REQ - 1);

    state_t             r_state;
    state_t             w_next;
    // Grant index doubles as the round-robin pointer: both always hold the
    // most recent pick, so one register serves as grant and last_grant.
    logic [IW-1:0]      r_grant;
    logic [2:0]         r_sel_q;
    logic [SPI_W-1:0]   r_spi_data;
    logic [SPI_W-1:0]   r_rdata;
    logic [CW-1:0]      r_cnt;

    logic [IW-1:0]      w_pick;
    logic               w_pick_vld;
    logic [2:0]         w_pick_sel;
    logic [SPI_W-1:0]   w_pick_data;
    logic               w_timeout;
    logic               w_active;

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (r_grant),
        .grant      (w_pick),
        .valid      (w_pick_vld)
    );

    // Select the picked requester's slave ID and write word
    always_comb begin
        w_pick_sel  = SLV_NONE;
        w_pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == IW'(i)) begin
                w_pick_sel  = req_sel[3*i +: 3];
                w_pick_data = req_wdata[SPI_W*i +: SPI_W];
            end
        end
    end

    assign w_timeout = (r_cnt == C_CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs; SPI_done beats the timeout
    always_comb begin
        w_next   = r_state;
        busy     = (r_state != ST_IDLE);
        wrt_SPI  = (r_state == ST_LAUNCH);
        w_active = (r_state == ST_LAUNCH) || (r_state == ST_BUSY);
        req_done = '0;
        req_err  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_done[i] = (r_state == ST_DONE) && (r_grant == IW'(i));
            req_err[i]  = (r_state == ST_ERR)  && (r_grant == IW'(i));
        end
        case (r_state)
            ST_IDLE:   if (w_pick_vld) w_next = sel_legal(w_pick_sel) ? ST_LAUNCH : ST_ERR;
            ST_LAUNCH: w_next = ST_BUSY;
            ST_BUSY: begin
                if (SPI_done)       w_next = ST_DONE;
                else if (w_timeout) w_next = ST_ERR;
            end
            ST_DONE:   w_next = ST_IDLE;
            ST_ERR:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Grant capture, saturating timeout counter and read-back capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= C_GNT_RST;
            r_sel_q    <= SLV_NONE;
            r_spi_data <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            if (r_state == ST_IDLE && w_pick_vld) begin
                r_grant    <= w_pick;
                r_sel_q    <= w_pick_sel;
                r_spi_data <= w_pick_data;
            end
            if (r_state == ST_LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == ST_BUSY && !w_timeout) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == ST_BUSY && SPI_done) begin
                r_rdata <= data_in;
            end
        end
    end

    assign SPI_data  = r_spi_data;
    assign rdata     = r_rdata;

    // A select goes low only while its device owns an active transfer
    assign trig_ss_n = SS_n | ~w_active | (r_sel_q != SLV_TRIG);
    assign ch1_ss_n  = SS_n | ~w_active | (r_sel_q != SLV_CH1);
    assign ch2_ss_n  = SS_n | ~w_active | (r_sel_q != SLV_CH2);
    assign ch3_ss_n  = SS_n | ~w_active | (r_sel_q != SLV_CH3);
    assign EEP_ss_n  = SS_n | ~w_active | (r_sel_q != SLV_EEP);

endmodule
`default_nettype wire

// File: tb/tb_spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_arb
// Description : Self-checking bench for spi_arb: transaction-level model
//               compared every cycle plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_arb;

    localparam int N  = 3;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [3*N-1:0]    req_sel = '0;
    logic [16*N-1:0]   req_wdata = '0;
    logic [N-1:0]      req_done, req_err;
    logic [15:0]       rdata, SPI_data;
    logic              busy, wrt_SPI;
    logic              SPI_done = 1'b0;
    logic [15:0]       data_in = '0;
    logic              SS_n = 1'b1;
    logic              trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n;

    spi_arb #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel),
        .req_wdata(req_wdata), .req_done(req_done), .req_err(req_err),
        .rdata(rdata), .busy(busy), .wrt_SPI(wrt_SPI), .SPI_data(SPI_data),
        .SPI_done(SPI_done), .data_in(data_in), .SS_n(SS_n),
        .trig_ss_n(trig_ss_n), .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n),
        .ch3_ss_n(ch3_ss_n), .EEP_ss_n(EEP_ss_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_wrt = -1;
    int wrt_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // mode: 0 no owner, 1 transfer in progress (age counts cycles since the
    // grant), 2 completion pulse cycle, 3 error pulse cycle
    int           m_mode = 0, m_age = 0, m_owner = 0, m_last = N-1;
    logic [2:0]   m_sel = 3'd7;
    logic [15:0]  m_data = '0, m_rdata = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    initial begin
        int p;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = 0; m_age = 0; m_last = N-1; m_sel = 3'd7;
                m_data = '0; m_rdata = '0;
            end else begin
                case (m_mode)
                    0: begin
                        p = rr_pick(req, m_last);
                        if (p >= 0) begin
                            m_owner = p; m_last = p; m_age = 1;
                            m_sel  = req_sel[3*p +: 3];
                            m_data = req_wdata[16*p +: 16];
                            m_mode = (m_sel <= 3'd4) ? 1 : 3;
                        end
                    end
                    1: begin
                        if (m_age >= 2 && SPI_done) begin
                            m_rdata = data_in; m_mode = 2;
                        end else if (m_age == TO + 1) begin
                            m_mode = 3;
                        end else begin
                            m_age++;
                        end
                    end
                    default: m_mode = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare + launch monitor ----------------
    logic [N-1:0] e_done, e_err;
    logic [4:0]   e_ss, a_ss;
    initial begin
        forever begin
            @(negedge clk); #1;
            if (rst_n) begin
                e_done = '0; e_err = '0;
                if (m_mode == 2) e_done[m_owner] = 1'b1;
                if (m_mode == 3) e_err[m_owner]  = 1'b1;
                for (int s = 0; s < 5; s++)
                    e_ss[4-s] = !(m_mode == 1 && int'(m_sel) == s && !SS_n);
                a_ss = {trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n};
                check("busy", busy, m_mode != 0);
                check("wrt_SPI", wrt_SPI, m_mode == 1 && m_age == 1);
                check("req_done", req_done, e_done);
                check("req_err", req_err, e_err);
                check("rdata", rdata, m_rdata);
                check("SPI_data", SPI_data, m_data);
                check("ss_n{trig,ch1,ch2,ch3,eep}", a_ss, e_ss);
                if (wrt_SPI) begin last_wrt = cyc; wrt_count++; end
            end
        end
    end

    // ---------------- SPI master responder ----------------
    bit          resp_en = 1'b0;
    int          resp_lat = 2;
    logic [15:0] resp_data = '0;
    initial begin
        int k;
        forever begin
            @(negedge clk);
            if (resp_en && rst_n && wrt_SPI) begin
                SS_n = 1'b0;
                k = 0;
                while (k < resp_lat && rst_n) begin @(negedge clk); k++; end
                if (rst_n) begin
                    SPI_done = 1'b1; data_in = resp_data;
                    @(negedge clk);
                    SPI_done = 1'b0;
                end
                SS_n = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk); #2;
    endtask

    task automatic wait_any(input int maxc, output int idx, output bit is_err, output int at);
        bit seen;
        idx = -1; is_err = 1'b0; at = -1; seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            step();
            if (|req_done || |req_err) begin
                seen = 1'b1; at = cyc;
                for (int i = 0; i < N; i++) begin
                    if (req_done[i]) idx = i;
                    if (req_err[i]) begin idx = i; is_err = 1'b1; end
                end
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL wait_pulse: no done/err within %0d cycles", maxc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int idx, at, w, wc;
        bit er;

        // Reset values
        repeat (3) step();
        check("rst busy", busy, 0);
        check("rst wrt_SPI", wrt_SPI, 0);
        check("rst SPI_data", SPI_data, 0);
        check("rst rdata", rdata, 0);
        check("rst selects", {trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n}, 5'h1F);
        check("rst done/err", {req_done, req_err}, 0);
        rst_n = 1'b1;
        step();

        // Contention from reset: order 0,1,2; two-cycle done-to-launch gap
        req_sel   = {3'd3, 3'd2, 3'd1};
        req_wdata = {16'h3333, 16'h2222, 16'h1111};
        resp_en = 1'b1; resp_lat = 2; resp_data = 16'h0B0B;
        req = 3'b111;
        step();
        check("contention first wrt", wrt_SPI, 1);
        check("contention first data", SPI_data, 16'h1111);
        for (int k = 0; k < 3; k++) begin
            wait_any(40, idx, er, at);
            check("contention order", idx, k);
            check("contention no err", er, 0);
            if (idx >= 0) req[idx] = 1'b0;
            if (k < 2) begin
                step(); step();
                check("done-to-launch gap 2", wrt_SPI, 1);
                check("next grant data", SPI_data, (k == 0) ? 16'h2222 : 16'h3333);
            end
        end

        // Pointer at 2: requester 0 goes ahead of 1
        req = 3'b011;
        wait_any(40, idx, er, at);
        check("pointer first", idx, 0);
        if (idx >= 0) req[idx] = 1'b0;
        wait_any(40, idx, er, at);
        check("pointer second", idx, 1);
        if (idx >= 0) req[idx] = 1'b0;
        step();

        // Single request to ch2
        req_sel[2:0] = 3'd2; req_wdata[15:0] = 16'hA55A;
        resp_lat = 3; resp_data = 16'h00C3;
        req[0] = 1'b1;
        step();
        check("single wrt", wrt_SPI, 1);
        check("single SPI_data", SPI_data, 16'hA55A);
        w = cyc;
        step();
        check("single ch2 low", {trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n}, 5'b11011);
        wait_any(40, idx, er, at);
        check("single done idx", idx, 0);
        check("single done latency", at - w, 4);
        check("single rdata", rdata, 16'h00C3);
        if (idx >= 0) req[idx] = 1'b0;
        step();

        // Illegal ID on requester 1
        req_sel[5:3] = 3'd6;
        wc = wrt_count;
        req[1] = 1'b1;
        step();
        check("illegal err pulse", req_err, 3'b010);
        check("illegal no wrt", wrt_SPI, 0);
        check("illegal selects", {trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n}, 5'h1F);
        req[1] = 1'b0;
        step(); step();
        check("illegal no launch", wrt_count, wc);
        check("illegal rdata kept", rdata, 16'h00C3);

        // Timeout: SPI_done arrives far too late and must be ignored
        req_sel[8:6] = 3'd4; req_wdata[47:32] = 16'h7E57;
        resp_lat = 25; resp_data = 16'hBEEF;
        req[2] = 1'b1;
        wait_any(60, idx, er, at);
        check("timeout idx", idx, 2);
        check("timeout is err", er, 1);
        check("timeout latency", at - last_wrt, TO + 1);
        if (idx >= 0) req[idx] = 1'b0;
        repeat (15) step();
        check("late SPI_done ignored rdata", rdata, 16'h00C3);
        check("late SPI_done ignored busy", busy, 0);

        // SPI_done on the final count wins over timeout
        req_sel[2:0] = 3'd3; req_wdata[15:0] = 16'h5150;
        resp_lat = TO; resp_data = 16'h0F0F;
        req[0] = 1'b1;
        wait_any(60, idx, er, at);
        check("race idx", idx, 0);
        check("race is done", er, 0);
        check("race latency", at - last_wrt, TO + 1);
        check("race rdata", rdata, 16'h0F0F);
        if (idx >= 0) req[idx] = 1'b0;
        step(); step();

        // Reset while BUSY on ch1
        req_sel[5:3] = 3'd1; req_wdata[31:16] = 16'h0111; req_sel[2:0] = 3'd0;
        resp_lat = 100;
        req[1] = 1'b1;
        step();
        repeat (4) step();
        check("pre-reset ch1 low", ch1_ss_n, 0);
        check("pre-reset busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst wrt", wrt_SPI, 0);
        check("async rst selects", {trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n}, 5'h1F);
        check("async rst SPI_data/rdata", {SPI_data, rdata}, 0);
        resp_lat = 2;
        req[0] = 1'b1;
        step(); step();
        rst_n = 1'b1;
        wait_any(40, idx, er, at);
        check("post-reset first grant", idx, 0);
        if (idx >= 0) req[idx] = 1'b0;
        wait_any(40, idx, er, at);
        check("post-reset second grant", idx, 1);
        if (idx >= 0) req[idx] = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
